// File: rtl/uart_tx_top.sv
// uart_tx_top: 8-bit UART transmitter with optional even/odd parity and a
// per-frame bit period (Prescale CLK cycles per bit, 0 or 1 treated as 8).
// Frame: start(0), data LSB first, optional parity, one stop(1).
// Optional feature: define UART_TX_HOLD_BUF_EN to add a one-byte holding
// register so a second byte can be queued and sent with zero idle gap.
// Without the macro TX_READY is asserted only while idle.
module uart_tx_top (
  input  logic       CLK,
  input  logic       RST,
  input  logic [7:0] P_DATA,
  input  logic       DATA_VALID,
  input  logic       PAR_EN,
  input  logic       PAR_TYP,
  input  logic [5:0] Prescale,
  output logic       TX_OUT,
  output logic       TX_READY,
  output logic       BUSY
);

  localparam int DATA_W = 8;

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  // Control state (reset)
  state_t      state_q, state_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [2:0]  bit_q, bit_d;
  logic        tx_out_q, tx_out_d;
  logic        busy_q, busy_d;
  logic        ready_q, ready_d;

  // Frame data latched at acceptance (no reset needed)
  logic [DATA_W-1:0] data_q, data_d;
  logic              par_en_q, par_en_d;
  logic              par_bit_q, par_bit_d;
  logic [5:0]        presc_q, presc_d;

`ifdef UART_TX_HOLD_BUF_EN
  logic              hold_full_q, hold_full_d;
  logic [DATA_W-1:0] hold_data_q, hold_data_d;
  logic              hold_par_en_q, hold_par_en_d;
  logic              hold_par_bit_q, hold_par_bit_d;
  logic [5:0]        hold_presc_q, hold_presc_d;
`endif

  logic accept;
  logic bit_done;

  // Bit periods below 2 cycles are not meaningful; fall back to 8.
  function automatic logic [5:0] eff_prescale(input logic [5:0] p);
    return (p < 6'd2) ? 6'd8 : p;
  endfunction

  // Even parity is the XOR of the data bits; odd parity is its inverse.
  function automatic logic parity_bit(input logic [DATA_W-1:0] d, input logic odd);
    return (^d) ^ odd;
  endfunction

  assign accept   = DATA_VALID && ready_q;
  assign bit_done = (cnt_q == presc_q - 6'd1);

  // Next-state, counters, frame latching and registered-output precompute.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_d     = bit_q;
    data_d    = data_q;
    par_en_d  = par_en_q;
    par_bit_d = par_bit_q;
    presc_d   = presc_q;
`ifdef UART_TX_HOLD_BUF_EN
    hold_full_d    = hold_full_q;
    hold_data_d    = hold_data_q;
    hold_par_en_d  = hold_par_en_q;
    hold_par_bit_d = hold_par_bit_q;
    hold_presc_d   = hold_presc_q;
`endif

    case (state_q)
      IDLE: begin
        if (accept) begin
          data_d    = P_DATA;
          par_en_d  = PAR_EN;
          par_bit_d = parity_bit(P_DATA, PAR_TYP);
          presc_d   = eff_prescale(Prescale);
          cnt_d     = 6'd0;
          bit_d     = 3'd0;
          state_d   = START;
        end
      end
      START: begin
        if (bit_done) begin
          cnt_d   = 6'd0;
          bit_d   = 3'd0;
          state_d = DATA;
        end else begin
          cnt_d = cnt_q + 6'd1;
        end
      end
      DATA: begin
        if (bit_done) begin
          cnt_d = 6'd0;
          if (bit_q == 3'd7) begin
            state_d = par_en_q ? PARITY : STOP;
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end else begin
          cnt_d = cnt_q + 6'd1;
        end
      end
      PARITY: begin
        if (bit_done) begin
          cnt_d   = 6'd0;
          state_d = STOP;
        end else begin
          cnt_d = cnt_q + 6'd1;
        end
      end
      STOP: begin
        if (bit_done) begin
          cnt_d   = 6'd0;
          bit_d   = 3'd0;
          state_d = IDLE;
`ifdef UART_TX_HOLD_BUF_EN
          // Chain the queued byte (or one offered right now) with no gap.
          if (hold_full_q) begin
            data_d      = hold_data_q;
            par_en_d    = hold_par_en_q;
            par_bit_d   = hold_par_bit_q;
            presc_d     = hold_presc_q;
            hold_full_d = 1'b0;
            state_d     = START;
          end else if (accept) begin
            data_d    = P_DATA;
            par_en_d  = PAR_EN;
            par_bit_d = parity_bit(P_DATA, PAR_TYP);
            presc_d   = eff_prescale(Prescale);
            state_d   = START;
          end
`endif
        end else begin
          cnt_d = cnt_q + 6'd1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = 6'd0;
        bit_d   = 3'd0;
      end
    endcase

`ifdef UART_TX_HOLD_BUF_EN
    // Bytes offered mid-frame are parked until the current stop bit ends.
    if (accept && (state_q != IDLE) && !((state_q == STOP) && bit_done)) begin
      hold_data_d    = P_DATA;
      hold_par_en_d  = PAR_EN;
      hold_par_bit_d = parity_bit(P_DATA, PAR_TYP);
      hold_presc_d   = eff_prescale(Prescale);
      hold_full_d    = 1'b1;
    end
`endif

    // Outputs are computed from the next state so they come straight off flops.
    case (state_d)
      START:   tx_out_d = 1'b0;
      DATA:    tx_out_d = data_d[bit_d];
      PARITY:  tx_out_d = par_bit_d;
      default: tx_out_d = 1'b1;
    endcase
    busy_d = (state_d != IDLE);
`ifdef UART_TX_HOLD_BUF_EN
    ready_d = !hold_full_d;
`else
    ready_d = (state_d == IDLE);
`endif
  end

  // Control registers with synchronous reset; reset aborts any frame.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q  <= IDLE;
      cnt_q    <= 6'd0;
      bit_q    <= 3'd0;
      tx_out_q <= 1'b1;
      busy_q   <= 1'b0;
      ready_q  <= 1'b1;
`ifdef UART_TX_HOLD_BUF_EN
      hold_full_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      bit_q    <= bit_d;
      tx_out_q <= tx_out_d;
      busy_q   <= busy_d;
      ready_q  <= ready_d;
`ifdef UART_TX_HOLD_BUF_EN
      hold_full_q <= hold_full_d;
`endif
    end
  end

  // Frame data registers; only ever read while the control state says valid.
  always_ff @(posedge CLK) begin
    data_q    <= data_d;
    par_en_q  <= par_en_d;
    par_bit_q <= par_bit_d;
    presc_q   <= presc_d;
`ifdef UART_TX_HOLD_BUF_EN
    hold_data_q    <= hold_data_d;
    hold_par_en_q  <= hold_par_en_d;
    hold_par_bit_q <= hold_par_bit_d;
    hold_presc_q   <= hold_presc_d;
`endif
  end

  assign TX_OUT   = tx_out_q;
  assign TX_READY = ready_q;
  assign BUSY     = busy_q;

endmodule
